mult_seq_ctrl: RTL and testbench

//  Multi-cycle shift-add multiply sequencer that borrows the execute-stage ALU.

---
 rtl/mult_seq_ctrl_if.sv | 36 +++
 rtl/mult_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_mult_seq_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mult_seq_ctrl_if.sv
// rtl/mult_seq_ctrl_if.sv - Issue handshake, result and shared-ALU drive bundle for mult_seq_ctrl
interface mult_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_result;

    logic             alu_req;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_src;
    logic             inv_a;
    logic             inv_b;
    logic             cin;
    logic             sign;

    logic             busy;
    logic             done;
    logic             stall;
    logic [WIDTH-1:0] product;

    modport master (
        output start, op_a, op_b, alu_result,
        input  alu_req, alu_op, alu_a, alu_b, alu_src, inv_a, inv_b, cin, sign,
        input  busy, done, stall, product
    );

    modport slave (
        input  start, op_a, op_b, alu_result,
        output alu_req, alu_op, alu_a, alu_b, alu_src, inv_a, inv_b, cin, sign,
        output busy, done, stall, product
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - Shift-add multiply sequencer that borrows the execute-stage ALU
module mult_seq_ctrl #(
    parameter int         WIDTH      = 16,
    parameter logic [2:0] ALU_OP_ADD = 3'b100,
    parameter bit         EARLY_EXIT = 1'b1
) (
    input logic            clk,
    input logic            rst,
    mult_seq_ctrl_if.slave bus
);
    localparam int             CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] p_nxt;
    logic [WIDTH-1:0] product;
    logic [CNT_W-1:0] cnt;
    logic             last_iter;

    logic             alu_req;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             busy;
    logic             done;
    logic             stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        alu_req   = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        busy      = 1'b0;
        done      = 1'b0;
        stall     = 1'b0;
        p_nxt     = q[0] ? bus.alu_result : p;
        // Early exit looks at the multiplier after this iteration's shift.
        last_iter = (cnt == CNT_LAST) || (EARLY_EXIT && ((q >> 1) == '0));
        case (state)
            IDLE: begin
                stall = bus.start;
                if (bus.start) begin
                    state_nxt = (bus.op_b != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                alu_req = 1'b1;
                alu_a   = p;
                alu_b   = m;
                busy    = 1'b1;
                stall   = 1'b1;
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p       <= '0;
            m       <= '0;
            q       <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        p   <= '0;
                        m   <= bus.op_a;
                        q   <= bus.op_b;
                        cnt <= '0;
                        if (bus.op_b == '0) begin
                            product <= '0;
                        end
                    end
                end
                RUN: begin
                    p   <= p_nxt;
                    m   <= m << 1;
                    q   <= q >> 1;
                    cnt <= cnt + 1'b1;
                    // Load product on DONE entry so it is valid alongside the done pulse.
                    if (last_iter) begin
                        product <= p_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.alu_req = alu_req;
    assign bus.alu_op  = ALU_OP_ADD;
    assign bus.alu_a   = alu_a;
    assign bus.alu_b   = alu_b;
    assign bus.alu_src = 1'b0;
    assign bus.inv_a   = 1'b0;
    assign bus.inv_b   = 1'b0;
    assign bus.cin     = 1'b0;
    assign bus.sign    = 1'b0;
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.stall   = stall;
    assign bus.product = product;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb/tb_mult_seq_ctrl.sv - Directed self-checking bench for mult_seq_ctrl
module tb_mult_seq_ctrl;
    localparam int         WIDTH  = 16;
    localparam logic [2:0] OP_ADD = 3'b100;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mult_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    mult_seq_ctrl #(
        .WIDTH      (WIDTH),
        .ALU_OP_ADD (OP_ADD),
        .EARLY_EXIT (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural shared ALU.
    assign bus.alu_result = bus.alu_a + bus.alu_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_drive(input string tag);
        check({tag, "_req"},  {31'd0, bus.alu_req}, 32'd0);
        check({tag, "_op"},   {29'd0, bus.alu_op}, {29'd0, OP_ADD});
        check({tag, "_ab"},   {bus.alu_a, bus.alu_b}, 32'd0);
        check({tag, "_ctl"},  {27'd0, bus.alu_src, bus.inv_a, bus.inv_b, bus.cin, bus.sign}, 32'd0);
    endtask

    // Issue one multiply and follow it to done; inject_at > 0 re-pulses start
    // (with 2*2) at that cycle of the run to show it is ignored.
    task automatic do_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_p, input int exp_lat, input int inject_at);
        int lat;
        int req_n;
        int stall_n;
        int bad_op;
        bit got;
        @(negedge clk);
        bus.op_a  = a;
        bus.op_b  = b;
        bus.start = 1'b1;
        #1;
        stall_n = bus.stall ? 1 : 0;
        lat     = 0;
        req_n   = 0;
        bad_op  = 0;
        got     = 1'b0;
        while (!got && lat < 60) begin
            @(negedge clk);
            lat++;
            if (bus.done) begin
                got = 1'b1;
                check({tag, "_prod"},       {16'd0, bus.product}, {16'd0, exp_p});
                check({tag, "_busy_done"},  {31'd0, bus.busy}, 32'd0);
                check({tag, "_stall_done"}, {31'd0, bus.stall}, 32'd0);
            end else begin
                if (bus.alu_req) req_n++;
                if (bus.stall) stall_n++;
                if (bus.alu_req && bus.alu_op != OP_ADD) bad_op++;
            end
            if (inject_at > 0 && lat == inject_at) begin
                bus.op_a  = 16'h0002;
                bus.op_b  = 16'h0002;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
        end
        check({tag, "_lat"},   lat, exp_lat);
        check({tag, "_req_n"}, req_n, exp_lat - 1);
        check({tag, "_stall_n"}, stall_n, exp_lat);
        check({tag, "_op"},    bad_op, 0);
        @(negedge clk);
        check({tag, "_pulse"}, {31'd0, bus.done}, 32'd0);
        check({tag, "_hold"},  {16'd0, bus.product}, {16'd0, exp_p});
        check_idle_drive({tag, "_idle"});
    endtask

    initial begin
        int seen;
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        repeat (2) @(negedge clk);
        check("rst_busy",  {31'd0, bus.busy}, 32'd0);
        check("rst_done",  {31'd0, bus.done}, 32'd0);
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
        check("rst_prod",  {16'd0, bus.product}, 32'd0);
        check_idle_drive("rst");
        rst = 1'b0;

        do_mul("m3x5",      16'h0003, 16'h0005, 16'h000F, 4,  0);
        do_mul("m1x8000",   16'h0001, 16'h8000, 16'h8000, 17, 0);
        do_mul("wrap",      16'h0100, 16'h0100, 16'h0000, 10, 0);
        do_mul("ffffx2",    16'hFFFF, 16'h0002, 16'hFFFE, 3,  0);
        do_mul("zero_b",    16'h1234, 16'h0000, 16'h0000, 1,  0);
        do_mul("ffffxffff", 16'hFFFF, 16'hFFFF, 16'h0001, 17, 0);
        do_mul("neg3x5",    16'hFFFD, 16'h0005, 16'hFFF1, 4,  0);
        do_mul("ignore",    16'h0007, 16'h0007, 16'h0031, 4,  2);

        // Reset during the third RUN cycle of 0xFF*0xFF.
        @(negedge clk);
        bus.op_a  = 16'h00FF;
        bus.op_b  = 16'h00FF;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_pre_busy", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy",  {31'd0, bus.busy}, 32'd0);
        check("abort_stall", {31'd0, bus.stall}, 32'd0);
        check("abort_prod",  {16'd0, bus.product}, 32'd0);
        check_idle_drive("abort");
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) seen = 1;
        end
        check("abort_no_done", seen, 0);
        do_mul("post_rst", 16'h0002, 16'h0003, 16'h0006, 3, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
